// File: rtl/relay_pkg.sv
// Purpose: shared types and constants for the memory-to-relay switching block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package relay_pkg;

    localparam int CNT_W             = 16;
    localparam int SETTLE_CYCLES_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2
    } relay_state_t;

    // Counter reload value for a phase lasting 'cycles' clocks (phase ends when the counter reads 0)
    function automatic logic [CNT_W-1:0] settle_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/mem_sync_stable.sv
// Purpose: two-flop synchroniser for the asynchronous memory word plus a compare stage that flags a settled sample.
// Latency: a new word is reported as stable 3 clk edges after it is captured.
// Backpressure: none; valid simply drops while consecutive synchronised samples differ.
module mem_sync_stable #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] memory,
    output logic [WIDTH-1:0] stable,
    output logic             valid
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cmp;

    // Synchroniser chain followed by the compare register holding the previous synchronised sample
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cmp   <= '0;
        end else begin
            sync1 <= memory;
            sync2 <= sync1;
            cmp   <= sync2;
        end
    end

    // A sample is trusted only once two consecutive synchronised values agree
    assign stable = cmp;
    assign valid  = (sync2 == cmp);

endmodule

// File: rtl/mem2relay.sv
// Purpose: sequence relay coils from a requested memory word (optional break-before-make with MEM2RELAY_BBM_EN).
// Latency: sequence starts 1 cycle after a stable change; each phase lasts SETTLE_CYCLES; done 1 cycle after the last MAKE cycle.
// Backpressure: memory changes are ignored while busy; a change still pending at IDLE starts the next sequence.
module mem2relay
    import relay_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] memory,
    output logic [WIDTH-1:0] relay,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = settle_load(SETTLE_CYCLES);

    relay_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] target, target_nxt;
    logic [WIDTH-1:0] applied, applied_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] stable;
    logic             valid;

    mem_sync_stable #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .memory (memory),
        .stable (stable),
        .valid  (valid)
    );

    // State, settle counter, latched target and last completed relay word
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            target  <= '0;
            applied <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            target  <= target_nxt;
            applied <= applied_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state logic; the counter saturates at 0 so it never wraps
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        target_nxt  = target;
        applied_nxt = applied;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (valid && (stable != applied)) begin
                    target_nxt = stable;
                    cnt_nxt    = CNT_LOAD;
`ifdef MEM2RELAY_BBM_EN
                    // Open coils that must drop before closing new ones
                    if ((applied & ~stable) != '0) state_nxt = BREAK;
                    else                           state_nxt = MAKE;
`else
                    state_nxt  = MAKE;
`endif
                end
            end
`ifdef MEM2RELAY_BBM_EN
            BREAK: begin
                if (cnt == '0) begin
                    state_nxt = MAKE;
                    cnt_nxt   = CNT_LOAD;
                end
            end
`endif
            MAKE: begin
                if (cnt == '0) begin
                    applied_nxt = target;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Coil drive follows the current phase; only coils common to old and new stay on during BREAK
    always_comb begin
        relay = applied;
        case (state)
`ifdef MEM2RELAY_BBM_EN
            BREAK:   relay = applied & target;
`endif
            MAKE:    relay = target;
            default: relay = applied;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem2relay.sv
// Purpose: directed self-checking bench for mem2relay with SETTLE_CYCLES = 4.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_mem2relay;

    localparam int W  = 16;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] memory;
    logic [W-1:0] relay;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem2relay #(
        .WIDTH         (W),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .memory (memory),
        .relay  (relay),
        .busy   (busy),
        .done   (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] r, input logic b, input logic d);
        chk({tag, ".relay"}, 32'(relay), 32'(r));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    // Three edges for the new word to reach the compare stage; relay holds the old value meanwhile
    task automatic settle_idle(input string tag, input logic [W-1:0] old_w);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_out({tag, ".idle"}, old_w, 1'b0, 1'b0);
        end
    endtask

    // Switching phases from the transition edge through the done cycle
    task automatic phases(input string tag, input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                          input logic chg_en, input logic [W-1:0] chg_val);
`ifdef MEM2RELAY_BBM_EN
        if ((old_w & ~new_w) != '0) begin
            for (int i = 0; i < SC; i++) begin
                tick;
                chk_out({tag, ".break"}, old_w & new_w, 1'b1, 1'b0);
            end
        end
`endif
        for (int i = 0; i < SC; i++) begin
            tick;
            chk_out({tag, ".make"}, new_w, 1'b1, 1'b0);
            if (chg_en && i == 0) memory = chg_val;
        end
        tick;
        chk_out({tag, ".done"}, new_w, 1'b0, 1'b1);
    endtask

    initial begin
        reset  = 1'b1;
        memory = '0;
        tick;
        tick;
        chk_out("reset", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        tick;
        chk_out("post_reset", 16'h0000, 1'b0, 1'b0);

        // Single-cycle pulse on memory must never be accepted
        memory = 16'h0100;
        tick;
        memory = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk_out("glitch", 16'h0000, 1'b0, 1'b0);
        end

        // Make-only from the reset state
        memory = 16'h0003;
        settle_idle("make_only", 16'h0000);
        phases("make_only", 16'h0000, 16'h0003, 1'b0, '0);
        tick;
        chk_out("make_only.post", 16'h0003, 1'b0, 1'b0);

        // Establish applied = 0x00F0
        memory = 16'h00F0;
        settle_idle("to_f0", 16'h0003);
        phases("to_f0", 16'h0003, 16'h00F0, 1'b0, '0);
        tick;
        chk_out("to_f0.post", 16'h00F0, 1'b0, 1'b0);

        // Disjoint word: BREAK to 0 then MAKE with BBM, direct MAKE without
        memory = 16'h000F;
        settle_idle("bbm", 16'h00F0);
        phases("bbm", 16'h00F0, 16'h000F, 1'b0, '0);
        tick;
        chk_out("bbm.post", 16'h000F, 1'b0, 1'b0);

        // Change during MAKE is deferred to a second back-to-back sequence
        memory = 16'h0001;
        settle_idle("busy_chg1", 16'h000F);
        phases("busy_chg1", 16'h000F, 16'h0001, 1'b1, 16'h0002);
        phases("busy_chg2", 16'h0001, 16'h0002, 1'b0, '0);
        tick;
        chk_out("busy_chg.post", 16'h0002, 1'b0, 1'b0);

        // Reset in the middle of MAKE, then restart with memory still non-zero
        memory = 16'h0006;
        settle_idle("rst_mid", 16'h0002);
        tick;
        chk_out("rst_mid.make0", 16'h0006, 1'b1, 1'b0);
        tick;
        chk_out("rst_mid.make1", 16'h0006, 1'b1, 1'b0);
        reset = 1'b1;
        tick;
        chk_out("rst_mid.reset", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        settle_idle("rst_restart", 16'h0000);
        phases("rst_restart", 16'h0000, 16'h0006, 1'b0, '0);
        tick;
        chk_out("rst_restart.post", 16'h0006, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
